// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: two-master round-robin/fixed-priority arbiter for the FPro MMIO bus; FPRO_ARB_LOCK_EN adds master lock ports
module fpro_bus_arbiter #(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 32,
    parameter int FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FPRO_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_rd_valid,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_rd_valid,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
    state_t state_q, state_d;
    logic last_q, last_d, gnt_q, gnt_d, wr_q, wr_d, win;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rd0_q, rd0_d, rd1_q, rd1_d;
`ifdef FPRO_ARB_LOCK_EN
    logic lock_q, lock_d;
`endif
    always_comb begin
        win = (m0_req & m1_req) ? ((FIXED_PRI != 0) ? 1'b0 : ~last_q) : m1_req;
`ifdef FPRO_ARB_LOCK_EN
        // a locked previous winner that still requests with lock keeps the bus
        if (lock_q && (last_q ? (m1_req & m1_lock) : (m0_req & m0_lock)))
            win = last_q;
        lock_d = lock_q;
`endif
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        case (state_q)
            IDLE: begin
                if (m0_req | m1_req) begin
                    state_d = BUS;
                    gnt_d   = win;
                    wr_d    = win ? m1_wr : m0_wr;
                    addr_d  = win ? m1_addr : m0_addr;
                    wdata_d = win ? m1_wr_data : m0_wr_data;
`ifdef FPRO_ARB_LOCK_EN
                    lock_d  = win ? m1_lock : m0_lock;
`endif
                end
`ifdef FPRO_ARB_LOCK_EN
                else lock_d = 1'b0;
`endif
            end
            BUS: begin
                state_d = DONE;
                if (!wr_q && gnt_q) rd1_d = mmio_rd_data;
                if (!wr_q && !gnt_q) rd0_d = mmio_rd_data;
            end
            DONE: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
`ifdef FPRO_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
`ifdef FPRO_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end
    assign mmio_cs      = state_q == BUS;
    assign mmio_wr      = mmio_cs & wr_q;
    assign mmio_rd      = mmio_cs & ~wr_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;
    assign m0_ack       = mmio_cs & ~gnt_q;
    assign m1_ack       = mmio_cs & gnt_q;
    assign m0_rd_valid  = (state_q == DONE) & ~wr_q & ~gnt_q;
    assign m1_rd_valid  = (state_q == DONE) & ~wr_q & gnt_q;
    assign m0_rd_data   = rd0_q;
    assign m1_rd_data   = rd1_q;
endmodule

// File: tb/tb_fpro_bus_arbiter.sv
// tb_fpro_bus_arbiter: directed bench; u0 is round-robin, u1 fixed-priority, both fed identical stimulus
module tb_fpro_bus_arbiter;
    logic clk = 0, reset = 1;
    logic m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0, m0_lock = 0, m1_lock = 0;
    logic [20:0] m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0, bus_rd = 0;
    logic cs, mwr, mrd, a0, a1, v0, v1;
    logic [20:0] maddr;
    logic [31:0] mwdata, d0, d1;
    logic f_cs, f_wr, f_rd, f_a0, f_a1, f_v0, f_v1;
    logic [20:0] f_addr;
    logic [31:0] f_wdata, f_d0, f_d1;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    fpro_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .FIXED_PRI(0)) u0 (
        .clk(clk), .reset(reset),
`ifdef FPRO_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wdata),
        .m0_ack(a0), .m0_rd_data(d0), .m0_rd_valid(v0),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wdata),
        .m1_ack(a1), .m1_rd_data(d1), .m1_rd_valid(v1),
        .mmio_cs(cs), .mmio_wr(mwr), .mmio_rd(mrd), .mmio_addr(maddr),
        .mmio_wr_data(mwdata), .mmio_rd_data(bus_rd));

    fpro_bus_arbiter #(.ADDR_W(21), .DATA_W(32), .FIXED_PRI(1)) u1 (
        .clk(clk), .reset(reset),
`ifdef FPRO_ARB_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wdata),
        .m0_ack(f_a0), .m0_rd_data(f_d0), .m0_rd_valid(f_v0),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wdata),
        .m1_ack(f_a1), .m1_rd_data(f_d1), .m1_rd_valid(f_v1),
        .mmio_cs(f_cs), .mmio_wr(f_wr), .mmio_rd(f_rd), .mmio_addr(f_addr),
        .mmio_wr_data(f_wdata), .mmio_rd_data(bus_rd));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cs", cs, 0);
        chk("rst_wr", mwr, 0);
        chk("rst_rd", mrd, 0);
        chk("rst_ack", {a0, a1, v0, v1}, 0);
        chk("rst_rdata", {d0, d1}, 0);
        chk("rst_addr", maddr, 0);
        reset = 0;
        @(negedge clk);
        chk("idle_cs", cs, 0);
        // m0 write from reset
        m0_req = 1; m0_wr = 1; m0_addr = 21'h00010; m0_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_strobes", {cs, mwr, mrd}, 3'b110);
        chk("wr_addr", maddr, 21'h00010);
        chk("wr_data", mwdata, 32'hDEADBEEF);
        chk("wr_ack", {a0, a1}, 2'b10);
        m0_req = 0;
        @(negedge clk);
        chk("wr_done_strobes", {cs, mwr, mrd, a0}, 0);
        chk("wr_no_valid", {v0, v1}, 0);
        chk("wr_addr_hold", maddr, 21'h00010);
        @(negedge clk);
        // m1 read
        m1_req = 1; m1_wr = 0; m1_addr = 21'h00404; bus_rd = 32'h12345678;
        @(negedge clk);
        chk("rd_strobes", {cs, mwr, mrd}, 3'b101);
        chk("rd_addr", maddr, 21'h00404);
        chk("rd_ack", {a0, a1}, 2'b01);
        m1_req = 0;
        @(negedge clk);
        bus_rd = 32'h0;
        chk("rd_valid", {v0, v1}, 2'b01);
        chk("rd_data", d1, 32'h12345678);
        chk("rd_m0_data", d0, 0);
        @(negedge clk);
        chk("rd_valid_pulse", v1, 0);
        chk("rd_data_hold", d1, 32'h12345678);
        // both masters request continuously
        m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr_ack%0d", i), {a0, a1}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("fp_ack%0d", i), {f_a0, f_a1}, 2'b10);
            repeat (2) @(negedge clk);
            chk($sformatf("gap_ack%0d", i), {a0, a1, f_a0, f_a1}, 0);
        end
        m0_req = 0;
        @(negedge clk);
        chk("fp_m1_after_drop", {f_a0, f_a1}, 2'b01);
        chk("rr_m1_after_drop", {a0, a1}, 2'b01);
        m1_req = 0;
        repeat (2) @(negedge clk);
        // reset in the middle of an m1 read
        m1_req = 1; m1_wr = 0; bus_rd = 32'hA5A5A5A5;
        @(negedge clk);
        chk("mid_bus_cs", {cs, mrd}, 2'b11);
        reset = 1;
        #1;
        chk("async_drop", {cs, mrd, a1}, 0);
        m1_req = 0;
        @(negedge clk);
        chk("abandon_valid", v1, 0);
        chk("abandon_data", d1, 0);
        reset = 0;
        m0_req = 1; m1_req = 1;
        @(negedge clk);
        chk("post_rst_m0_wins", {a0, a1}, 2'b10);
        m0_req = 0; m1_req = 0;
        repeat (2) @(negedge clk);
`ifdef FPRO_ARB_LOCK_EN
        m0_req = 1; m1_req = 1; m1_lock = 1; m1_wr = 0; m1_addr = 21'h00020; bus_rd = 32'hCAFE0001;
        @(negedge clk);
        chk("lock_rd_ack", {a0, a1}, 2'b01);
        m1_wr = 1; m1_wdata = 32'h0BAD0002;
        @(negedge clk);
        chk("lock_rd_data", {v1, d1}, {1'b1, 32'hCAFE0001});
        @(negedge clk);
        @(negedge clk);
        chk("lock_wr_ack", {a0, a1, mwr}, 3'b011);
        m1_req = 0; m1_lock = 0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("lock_release_m0", {a0, a1}, 2'b10);
        m0_req = 0;
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
